// File: rtl/hello_scroller_if.sv
// Board-side bundle for the HELLO scroller: control inputs plus rotation,
// strobe and seven-segment outputs.
interface hello_scroller_if;
  logic       run;
  logic       dir;
  logic       step;
  logic       load;
  logic [2:0] pos;
  logic [2:0] rot;
  logic       step_pulse;
  logic [0:6] hex0;
  logic [0:6] hex1;
  logic [0:6] hex2;
  logic [0:6] hex3;
  logic [0:6] hex4;

  modport master (
    output run, dir, step, load, pos,
    input  rot, step_pulse, hex0, hex1, hex2, hex3, hex4
  );

  modport slave (
    input  run, dir, step, load, pos,
    output rot, step_pulse, hex0, hex1, hex2, hex3, hex4
  );
endinterface

// File: rtl/hello_scroller.sv
// Timed "HELLO" scroller: prescaler tick or paused single-step rotates a mod-5
// counter whose next value drives registered active-low seven-segment digits.
module hello_scroller #(
  parameter int TICKS_PER_STEP = 50_000_000,
  parameter int CNT_W          = 26
) (
  input logic              clk,
  input logic              rst,
  hello_scroller_if.slave  bus
);

  typedef enum logic {ST_PAUSED = 1'b0, ST_RUNNING = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);

  localparam logic [0:6] SEG_H = 7'b0001001;
  localparam logic [0:6] SEG_E = 7'b0000110;
  localparam logic [0:6] SEG_L = 7'b1000111;
  localparam logic [0:6] SEG_O = 7'b1000000;

  // Letter at position idx of the word H E L L O.
  function automatic logic [0:6] letter(input logic [3:0] idx);
    case (idx)
      4'd0:       letter = SEG_H;
      4'd1:       letter = SEG_E;
      4'd2, 4'd3: letter = SEG_L;
      default:    letter = SEG_O;
    endcase
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rot_q, rot_d;
  logic             step_pulse_q, step_pulse_d;
  logic [0:6]       hex_q [5];
  logic [0:6]       hex_d [5];

  logic tick;
  logic load_ok;
  logic advance;

  // Run is a plain level; the state follows it on the same cycle so a pause
  // coinciding with the terminal count suppresses that tick.
  always_comb begin
    state   = bus.run ? ST_RUNNING : ST_PAUSED;
    load_ok = bus.load && (bus.pos <= 3'd4);
    tick    = (state == ST_RUNNING) && (cnt_q == CNT_LAST);
    advance = !load_ok && (tick || ((state == ST_PAUSED) && bus.step));
  end

  always_comb begin
    cnt_d        = cnt_q;
    rot_d        = rot_q;
    step_pulse_d = 1'b0;

    if (load_ok) begin
      cnt_d = '0;
    end else if (state == ST_RUNNING) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    if (load_ok) begin
      rot_d = bus.pos;
    end else if (advance) begin
      step_pulse_d = 1'b1;
      if (bus.dir) begin
        rot_d = (rot_q == 3'd0) ? 3'd4 : rot_q - 3'd1;
      end else begin
        rot_d = (rot_q >= 3'd4) ? 3'd0 : rot_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      rot_q        <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rot_q        <= rot_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  // Digit gi shows word letter (4 - gi + k) mod 5, taken from the next k so
  // the display lands on the same edge as Rot.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_digit
      logic [3:0] sum;
      assign sum = 4'(4 - gi) + {1'b0, rot_d};

      always_comb begin
        hex_d[gi] = letter((sum >= 4'd5) ? sum - 4'd5 : sum);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          hex_q[gi] <= letter(4'(4 - gi));
        end else begin
          hex_q[gi] <= hex_d[gi];
        end
      end
    end
  endgenerate

  assign bus.rot        = rot_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.hex0       = hex_q[0];
  assign bus.hex1       = hex_q[1];
  assign bus.hex2       = hex_q[2];
  assign bus.hex3       = hex_q[3];
  assign bus.hex4       = hex_q[4];

endmodule

// File: tb/tb_hello_scroller.sv
// Bench for hello_scroller: stimulus table, hand-written corner sequences and
// randomized traffic, all checked against a cycle-level model of the rules.
module tb_hello_scroller;
  localparam int T = 4;

  localparam logic [6:0] C_H = 7'b0001001;
  localparam logic [6:0] C_E = 7'b0000110;
  localparam logic [6:0] C_L = 7'b1000111;
  localparam logic [6:0] C_O = 7'b1000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hello_scroller_if bus ();

  hello_scroller #(.TICKS_PER_STEP(T), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_rot = 0;
  int   m_cnt = 0;
  logic m_pulse = 1'b0;

  typedef struct {
    logic       rst, run, dir, step, load;
    logic [2:0] pos;
    int         exp_rot;
    logic       exp_pulse;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [34:0] exp_hex(input int k);
    string      w = "HELLO";
    logic [34:0] r = '0;
    for (int i = 4; i >= 0; i--) begin
      logic [6:0] c;
      case (w[(4 - i + k) % 5])
        "H":     c = C_H;
        "E":     c = C_E;
        "L":     c = C_L;
        default: c = C_O;
      endcase
      r = {r[27:0], c};
    end
    return r;
  endfunction

  function automatic logic [34:0] dut_hex();
    return {bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
  endfunction

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the reference, compare after the edge.
  task automatic cyc(input logic r, input logic run, input logic dir,
                     input logic step, input logic load, input logic [2:0] pos);
    rst = r; bus.run = run; bus.dir = dir; bus.step = step; bus.load = load; bus.pos = pos;
    m_pulse = 1'b0;
    if (r) begin
      m_rot = 0; m_cnt = 0;
    end else if (load && pos < 5) begin
      m_rot = pos; m_cnt = 0;
    end else if (run) begin
      if (m_cnt == T - 1) begin
        m_cnt = 0; m_rot = (m_rot + (dir ? 4 : 1)) % 5; m_pulse = 1'b1;
      end else begin
        m_cnt++;
      end
    end else if (step) begin
      m_rot = (m_rot + (dir ? 4 : 1)) % 5; m_pulse = 1'b1;
    end
    @(posedge clk);
    #1;
    check("model_rot", 35'(bus.rot), 35'(m_rot));
    check("model_pulse", 35'(bus.step_pulse), 35'(m_pulse));
    check("model_hex", dut_hex(), exp_hex(m_rot));
    $display("cyc rst=%0b run=%0b dir=%0b step=%0b load=%0b pos=%0d -> rot=%0d pulse=%0b",
             r, run, dir, step, load, pos, bus.rot, bus.step_pulse);
  endtask

  // Run until a StepPulse appears; n = clocks taken, 0 if none within budget.
  task automatic wait_tick(input logic dir, output int n);
    n = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 1'b1, dir, 1'b0, 1'b0, 3'd0);
      if (bus.step_pulse === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b1; bus.run = 0; bus.dir = 0; bus.step = 0; bus.load = 0; bus.pos = 0;

    // Reset, 21 running clocks left, then three more to the right.
    tbl.push_back('{1, 0, 0, 0, 0, 3'd0, 0, 1'b0});
    for (int c = 1; c <= 21; c++)
      tbl.push_back('{0, 1, 0, 0, 0, 3'd0, (c / 4) % 5, (c % 4) == 0});
    tbl.push_back('{0, 1, 1, 0, 0, 3'd0, 0, 1'b0});
    tbl.push_back('{0, 1, 1, 0, 0, 3'd0, 0, 1'b0});
    tbl.push_back('{0, 1, 1, 0, 0, 3'd0, 4, 1'b1});

    pulses = 0;
    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].run, tbl[i].dir, tbl[i].step, tbl[i].load, tbl[i].pos);
      check("tbl_rot", 35'(bus.rot), 35'(tbl[i].exp_rot));
      check("tbl_pulse", 35'(bus.step_pulse), 35'(tbl[i].exp_pulse));
      if (i <= 21 && bus.step_pulse === 1'b1) pulses++;
    end
    check("pulse_count", 35'(pulses), 35'd5);
    check("hex_k4", dut_hex(), {C_O, C_H, C_E, C_L, C_L});

    // Pause preserves phase: 2 running + 10 paused, tick 2 clocks after resume.
    cyc(1, 0, 0, 0, 0, 3'd0);
    check("reset_hex", dut_hex(), {C_H, C_E, C_L, C_L, C_O});
    repeat (2) cyc(0, 1, 0, 0, 0, 3'd0);
    repeat (10) cyc(0, 0, 0, 0, 0, 3'd0);
    check("pause_rot", 35'(bus.rot), 35'd0);
    wait_tick(1'b0, n);
    check("resume_latency", 35'(n), 35'd2);

    // Paused steps from 3, then a step while running is ignored.
    cyc(0, 0, 0, 0, 1, 3'd3);
    cyc(0, 0, 0, 1, 0, 3'd0); check("step1", 35'(bus.rot), 35'd4);
    cyc(0, 0, 0, 0, 0, 3'd0);
    cyc(0, 0, 0, 1, 0, 3'd0); check("step2", 35'(bus.rot), 35'd0);
    cyc(0, 0, 0, 1, 0, 3'd0); check("step3", 35'(bus.rot), 35'd1);
    check("step3_pulse", 35'(bus.step_pulse), 35'd1);
    cyc(0, 1, 0, 1, 0, 3'd0);
    check("run_step_rot", 35'(bus.rot), 35'd1);
    check("run_step_pulse", 35'(bus.step_pulse), 35'd0);

    // Illegal load ignored; legal load wins over a coincident tick.
    cyc(0, 0, 0, 0, 1, 3'd6); check("load6", 35'(bus.rot), 35'd1);
    repeat (2) cyc(0, 1, 0, 0, 0, 3'd0);
    cyc(0, 1, 0, 0, 1, 3'd2);
    check("load_tick_rot", 35'(bus.rot), 35'd2);
    check("load_tick_pulse", 35'(bus.step_pulse), 35'd0);
    check("hex_k2", dut_hex(), {C_L, C_L, C_O, C_H, C_E});
    wait_tick(1'b0, n);
    check("load_latency", 35'(n), 35'd4);
    check("load_next_rot", 35'(bus.rot), 35'd3);

    // Run falls exactly at terminal count: no tick, fires on first run edge.
    repeat (3) cyc(0, 1, 0, 0, 0, 3'd0);
    cyc(0, 0, 0, 0, 0, 3'd0);
    check("fall_no_tick", 35'(bus.step_pulse), 35'd0);
    repeat (3) cyc(0, 0, 0, 0, 0, 3'd0);
    wait_tick(1'b0, n);
    check("rise_latency", 35'(n), 35'd1);

    // Reset mid-scroll at k=3, cnt=2.
    cyc(0, 0, 0, 0, 1, 3'd3);
    repeat (2) cyc(0, 1, 0, 0, 0, 3'd0);
    cyc(1, 1, 0, 0, 0, 3'd0);
    check("midreset_rot", 35'(bus.rot), 35'd0);
    check("midreset_hex", dut_hex(), {C_H, C_E, C_L, C_L, C_O});
    wait_tick(1'b0, n);
    check("midreset_latency", 35'(n), 35'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(63) == 0, $urandom_range(3) != 0, 1'($urandom),
          $urandom_range(3) == 0, $urandom_range(15) == 0, 3'($urandom_range(7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
